// File: rtl/vram_arbiter.sv
// Framebuffer RAM arbiter: keeps the scan-out prefetch FIFO topped up and
// shares the remaining RAM bandwidth round-robin between two writers.
module vram_arbiter #(
    parameter int ADDR_W   = 19,
    parameter int DATA_W   = 8,
    parameter int FB_WORDS = 307200,
    parameter int DEPTH    = 16,
    parameter int LOW_WM   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              pix_pop,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    output logic              underflow,
    input  logic              underflow_clr,
    input  logic              wr0_req,
    input  logic              wr1_req,
    input  logic [ADDR_W-1:0] wr0_addr,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic [DATA_W-1:0] wr0_data,
    input  logic [DATA_W-1:0] wr1_data,
    output logic              wr0_gnt,
    output logic              wr1_gnt,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int OCC_W = PTR_W + 2;
    localparam logic [OCC_W-1:0]  LOW_WM_OCC = OCC_W'(LOW_WM);
    localparam logic [OCC_W-1:0]  DEPTH_OCC  = OCC_W'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(FB_WORDS - 1);

    logic [DATA_W-1:0] fifo_mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [LVL_W-1:0]  level;
    logic              infl0;
    logic              infl1;
    logic [ADDR_W-1:0] fetch_addr;
    logic              rr_ptr;

    logic [OCC_W-1:0]  occ;
    logic              urgent;
    logic              room;
    logic              any_req;
    logic              sel1;
    logic              do_read;
    logic              do_write;
    logic              push;
    logic              pop_ok;
    logic              uf_event;

    // In-flight reads count against capacity so a refill can never overflow.
    assign occ      = OCC_W'(level) + OCC_W'(infl0) + OCC_W'(infl1);
    assign urgent   = occ < LOW_WM_OCC;
    assign room     = occ < DEPTH_OCC;
    assign any_req  = wr0_req | wr1_req;
    assign sel1     = wr1_req & (~wr0_req | rr_ptr);

    assign do_read  = ~frame_start & (urgent | (~any_req & room));
    assign do_write = ~frame_start & ~urgent & any_req;
    assign wr0_gnt  = do_write & ~sel1;
    assign wr1_gnt  = do_write & sel1;

    assign push     = infl1 & ~frame_start;
    assign pop_ok   = pix_pop & ~frame_start & (level != '0);
    assign uf_event = pix_pop & ~frame_start & (level == '0);

    assign pix_valid = (level != '0);
    assign pix_data  = pix_valid ? fifo_mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= mem_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            level      <= '0;
            infl0      <= 1'b0;
            infl1      <= 1'b0;
            fetch_addr <= '0;
            rr_ptr     <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            mem_en <= do_read | do_write;
            mem_we <= do_write;
            if (do_write) begin
                mem_addr  <= sel1 ? wr1_addr : wr0_addr;
                mem_wdata <= sel1 ? wr1_data : wr0_data;
                rr_ptr    <= ~sel1;
            end else if (do_read) begin
                mem_addr <= fetch_addr;
            end

            // Clearing both stages on frame_start discards their returning data.
            infl0 <= do_read;
            infl1 <= infl0 & ~frame_start;

            if (frame_start) begin
                fetch_addr <= '0;
            end else if (do_read) begin
                fetch_addr <= (fetch_addr == LAST_ADDR) ? '0 : fetch_addr + ADDR_W'(1);
            end

            if (frame_start) begin
                rd_ptr <= wr_ptr;
                level  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop_ok) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                level <= level + LVL_W'(push) - LVL_W'(pop_ok);
            end

            if (uf_event) begin
                underflow <= 1'b1;
            end else if (underflow_clr) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: fill, writer round-robin, low-watermark
// refill, underflow, frame restart, address wrap and reset mid-read.
module tb_vram_arbiter;

    localparam int AW = 19;
    localparam int DW = 8;
    localparam int FB = 100;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          frame_start = 1'b0;
    logic          pix_pop = 1'b0;
    logic [DW-1:0] pix_data;
    logic          pix_valid;
    logic          underflow;
    logic          underflow_clr = 1'b0;
    logic          wr0_req = 1'b0;
    logic          wr1_req = 1'b0;
    logic [AW-1:0] wr0_addr = '0;
    logic [AW-1:0] wr1_addr = '0;
    logic [DW-1:0] wr0_data = '0;
    logic [DW-1:0] wr1_data = '0;
    logic          wr0_gnt;
    logic          wr1_gnt;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    int   checks = 0;
    int   failures = 0;
    int   occ_m = 0;
    logic ptr_m = 1'b0;

    vram_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .FB_WORDS(FB), .DEPTH(16), .LOW_WM(4)
    ) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start),
        .pix_pop(pix_pop), .pix_data(pix_data), .pix_valid(pix_valid),
        .underflow(underflow), .underflow_clr(underflow_clr),
        .wr0_req(wr0_req), .wr1_req(wr1_req),
        .wr0_addr(wr0_addr), .wr1_addr(wr1_addr),
        .wr0_data(wr0_data), .wr1_data(wr1_data),
        .wr0_gnt(wr0_gnt), .wr1_gnt(wr1_gnt),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
        logic [7:0] lo;
        lo = a[7:0];
        return (lo * 8'd7) ^ 8'hA5;
    endfunction

    // One-cycle-latency RAM with fixed contents.
    always @(posedge clk) begin
        if (mem_en && !mem_we) mem_rdata <= ram_word(mem_addr);
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        wr0_req = 1'b1;
        repeat (2) cycle();
        checks++;
        if ({mem_en, mem_we, wr0_gnt, wr1_gnt, pix_valid, underflow} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=000000",
                     {mem_en, mem_we, wr0_gnt, wr1_gnt, pix_valid, underflow});
        end
        checks++;
        if (mem_addr !== '0 || mem_wdata !== '0 || pix_data !== '0) begin
            failures++;
            $display("FAIL reset_data addr=%0d wdata=%h pix=%h exp all 0", mem_addr, mem_wdata, pix_data);
        end
        wr0_req = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_fill();
        for (int k = 1; k <= 18; k++) begin
            cycle();
            checks++;
            if (k <= 16) begin
                if (!(mem_en === 1'b1 && mem_we === 1'b0 && mem_addr === AW'(k - 1))) begin
                    failures++;
                    $display("FAIL fill_read k=%0d en=%b we=%b addr=%0d exp read addr=%0d",
                             k, mem_en, mem_we, mem_addr, k - 1);
                end
                occ_m++;
            end else if (mem_en !== 1'b0) begin
                failures++;
                $display("FAIL fill_stop k=%0d en=%b exp 0", k, mem_en);
            end
            if (k == 2) begin
                checks++;
                if (pix_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL fill_latency valid=%b exp 0", pix_valid);
                end
            end
            if (k == 3 || k == 18) begin
                checks++;
                if (pix_valid !== 1'b1 || pix_data !== ram_word('0)) begin
                    failures++;
                    $display("FAIL fill_head k=%0d valid=%b data=%h exp 1/%h", k, pix_valid, pix_data, ram_word('0));
                end
            end
        end
    endtask

    task automatic test_writers();
        logic exp_sel1;
        wr0_req = 1'b1;
        wr1_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wr0_addr = AW'(32'h1000 + i);
            wr0_data = DW'(8'h10 + i);
            wr1_addr = AW'(32'h2000 + i);
            wr1_data = DW'(8'h20 + i);
            exp_sel1 = ptr_m;
            #2;
            checks++;
            if ({wr0_gnt, wr1_gnt} !== (exp_sel1 ? 2'b01 : 2'b10)) begin
                failures++;
                $display("FAIL rr_gnt i=%0d got=%b exp=%b", i, {wr0_gnt, wr1_gnt}, exp_sel1 ? 2'b01 : 2'b10);
            end
            cycle();
            checks++;
            if (mem_en !== 1'b1 || mem_we !== 1'b1 ||
                mem_addr !== (exp_sel1 ? AW'(32'h2000 + i) : AW'(32'h1000 + i)) ||
                mem_wdata !== (exp_sel1 ? DW'(8'h20 + i) : DW'(8'h10 + i))) begin
                failures++;
                $display("FAIL rr_write i=%0d en=%b we=%b addr=%h data=%h exp writer%0d",
                         i, mem_en, mem_we, mem_addr, mem_wdata, exp_sel1);
            end
            ptr_m = ~exp_sel1;
        end
    endtask

    task automatic test_single_writer();
        wr0_req = 1'b0;
        wr1_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr1_addr = AW'(32'h3000 + i);
            wr1_data = DW'(8'h30 + i);
            #2;
            checks++;
            if ({wr0_gnt, wr1_gnt} !== 2'b01) begin
                failures++;
                $display("FAIL single_gnt i=%0d got=%b exp=01", i, {wr0_gnt, wr1_gnt});
            end
            cycle();
            checks++;
            if (mem_we !== 1'b1 || mem_addr !== AW'(32'h3000 + i) || mem_wdata !== DW'(8'h30 + i)) begin
                failures++;
                $display("FAIL single_write i=%0d we=%b addr=%h data=%h", i, mem_we, mem_addr, mem_wdata);
            end
        end
        ptr_m = 1'b0;
    endtask

    task automatic test_low_watermark();
        logic exp_read;
        wr0_req = 1'b1;
        wr1_req = 1'b1;
        for (int i = 0; i < 60; i++) begin
            pix_pop  = (i % 2 == 1);
            wr0_addr = AW'(32'h4000 + i);
            wr1_addr = AW'(32'h5000 + i);
            wr0_data = DW'(i);
            wr1_data = DW'(8'h80 + i);
            exp_read = (occ_m < 4);
            #2;
            if (pix_pop) begin
                checks++;
                if (pix_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL lwm_starve i=%0d valid=%b exp 1", i, pix_valid);
                end
            end
            checks++;
            if ({wr0_gnt, wr1_gnt} !== (exp_read ? 2'b00 : (ptr_m ? 2'b01 : 2'b10))) begin
                failures++;
                $display("FAIL lwm_gnt i=%0d occ=%0d got=%b", i, occ_m, {wr0_gnt, wr1_gnt});
            end
            cycle();
            checks++;
            if (exp_read) begin
                if (mem_en !== 1'b1 || mem_we !== 1'b0) begin
                    failures++;
                    $display("FAIL lwm_refill i=%0d en=%b we=%b exp read", i, mem_en, mem_we);
                end
                occ_m++;
            end else begin
                if (mem_en !== 1'b1 || mem_we !== 1'b1 ||
                    mem_addr !== (ptr_m ? AW'(32'h5000 + i) : AW'(32'h4000 + i))) begin
                    failures++;
                    $display("FAIL lwm_write i=%0d en=%b we=%b addr=%h", i, mem_en, mem_we, mem_addr);
                end
                ptr_m = ~ptr_m;
            end
            if (pix_pop) occ_m--;
        end
        pix_pop = 1'b0;
        wr0_req = 1'b0;
        wr1_req = 1'b0;
        checks++;
        if (underflow !== 1'b0) begin
            failures++;
            $display("FAIL lwm_underflow got=%b exp 0", underflow);
        end
    endtask

    task automatic test_underflow();
        frame_start = 1'b1;
        cycle();
        frame_start = 1'b0;
        pix_pop = 1'b1;
        #2;
        checks++;
        if (pix_valid !== 1'b0) begin
            failures++;
            $display("FAIL uf_flush valid=%b exp 0", pix_valid);
        end
        cycle();
        checks++;
        if (underflow !== 1'b1 || pix_valid !== 1'b0 || mem_en !== 1'b1 || mem_addr !== '0) begin
            failures++;
            $display("FAIL uf_set uf=%b valid=%b en=%b addr=%0d exp 1/0/1/0", underflow, pix_valid, mem_en, mem_addr);
        end
        pix_pop = 1'b0;
        underflow_clr = 1'b1;
        cycle();
        checks++;
        if (underflow !== 1'b0 || pix_valid !== 1'b0) begin
            failures++;
            $display("FAIL uf_clr uf=%b valid=%b exp 0/0", underflow, pix_valid);
        end
        underflow_clr = 1'b0;
        pix_pop = 1'b1;
        cycle();
        checks++;
        if (underflow !== 1'b1 || pix_valid !== 1'b1 || pix_data !== ram_word('0)) begin
            failures++;
            $display("FAIL uf_push_kept uf=%b valid=%b data=%h exp 1/1/%h", underflow, pix_valid, pix_data, ram_word('0));
        end
        pix_pop = 1'b0;
        frame_start = 1'b1;
        underflow_clr = 1'b1;
        cycle();
        checks++;
        if (underflow !== 1'b0 || pix_valid !== 1'b0) begin
            failures++;
            $display("FAIL uf_clr_fs uf=%b valid=%b exp 0/0", underflow, pix_valid);
        end
        frame_start = 1'b0;
        pix_pop = 1'b1;
        cycle();
        checks++;
        if (underflow !== 1'b1) begin
            failures++;
            $display("FAIL uf_set_wins uf=%b exp 1", underflow);
        end
        pix_pop = 1'b0;
        cycle();
        checks++;
        if (underflow !== 1'b0) begin
            failures++;
            $display("FAIL uf_clr2 uf=%b exp 0", underflow);
        end
        underflow_clr = 1'b0;
        repeat (20) cycle();
    endtask

    task automatic test_frame_restart();
        logic found;
        int   prev_rd;
        int   rd_before;
        found = 1'b0;
        prev_rd = -1;
        rd_before = -1;
        pix_pop = 1'b1;
        for (int i = 0; i < 100 && !found; i++) begin
            cycle();
            if (mem_en && !mem_we) begin
                if (mem_addr == AW'(41)) begin
                    found = 1'b1;
                    rd_before = prev_rd;
                end
                prev_rd = int'(mem_addr);
            end else begin
                prev_rd = -1;
            end
        end
        checks++;
        if (!found || rd_before != 40) begin
            failures++;
            $display("FAIL fs_seek found=%b prev_read=%0d exp 1/40", found, rd_before);
        end
        if (found) begin
            frame_start = 1'b1;
            wr0_req = 1'b1;
            wr0_addr = AW'(32'h7000);
            #2;
            checks++;
            if ({wr0_gnt, wr1_gnt} !== 2'b00) begin
                failures++;
                $display("FAIL fs_no_gnt got=%b exp 00", {wr0_gnt, wr1_gnt});
            end
            cycle();
            frame_start = 1'b0;
            pix_pop = 1'b0;
            wr0_req = 1'b0;
            checks++;
            if (pix_valid !== 1'b0 || mem_en !== 1'b0 || underflow !== 1'b0) begin
                failures++;
                $display("FAIL fs_flush valid=%b en=%b uf=%b exp 0/0/0", pix_valid, mem_en, underflow);
            end
            for (int k = 0; k < 2; k++) begin
                cycle();
                checks++;
                if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== AW'(k) || pix_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL fs_restart k=%0d en=%b addr=%0d valid=%b exp 1/%0d/0", k, mem_en, mem_addr, pix_valid, k);
                end
            end
            cycle();
            checks++;
            if (pix_valid !== 1'b1 || pix_data !== ram_word('0)) begin
                failures++;
                $display("FAIL fs_first_word valid=%b data=%h exp 1/%h", pix_valid, pix_data, ram_word('0));
            end
        end
        pix_pop = 1'b0;
    endtask

    task automatic test_wrap_and_reset();
        logic found;
        found = 1'b0;
        repeat (20) cycle();
        pix_pop = 1'b1;
        for (int i = 0; i < 200 && !found; i++) begin
            cycle();
            if (mem_en && !mem_we && mem_addr == AW'(FB - 1)) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL wrap_seek no read at %0d within bound", FB - 1);
        end
        cycle();
        checks++;
        if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== '0 || underflow !== 1'b0) begin
            failures++;
            $display("FAIL wrap_addr en=%b we=%b addr=%0d uf=%b exp 1/0/0/0", mem_en, mem_we, mem_addr, underflow);
        end
        pix_pop = 1'b0;
        wr1_req = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({mem_en, mem_we, wr0_gnt, wr1_gnt, pix_valid, underflow} !== 6'b0 ||
            pix_data !== '0 || mem_addr !== '0 || mem_wdata !== '0) begin
            failures++;
            $display("FAIL rst_async flags=%b pix=%h addr=%0d wdata=%h exp all 0",
                     {mem_en, mem_we, wr0_gnt, wr1_gnt, pix_valid, underflow}, pix_data, mem_addr, mem_wdata);
        end
        cycle();
        cycle();
        rst = 1'b0;
        wr1_req = 1'b0;
        cycle();
        checks++;
        if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== '0 || pix_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_first_read en=%b addr=%0d valid=%b exp 1/0/0", mem_en, mem_addr, pix_valid);
        end
        cycle();
        checks++;
        if (pix_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_no_stale_push valid=%b exp 0", pix_valid);
        end
        cycle();
        checks++;
        if (pix_valid !== 1'b1 || pix_data !== ram_word('0)) begin
            failures++;
            $display("FAIL rst_first_word valid=%b data=%h exp 1/%h", pix_valid, pix_data, ram_word('0));
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_writers();
        test_single_writer();
        test_low_watermark();
        test_underflow();
        test_frame_restart();
        test_wrap_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
